buffered_data_memory: RTL and testbench

- Byte-addressed data memory with a request/response handshake, a configurable read latency and a posted-store buffer.
- Replaces the single-cycle data memory in the MEM stage.
- Performs load sign/zero extension internally and reports range, alignment and size errors on the response channel.
- Stores are queued and drained one per cycle. Loads merge pending stores byte-wise, so the program-order view is preserved.

---
 rtl/buffered_data_memory_if.sv | 30 +++
 rtl/buffered_data_memory.sv | 173 +++++++++++++++++
 tb/tb_buffered_data_memory.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buffered_data_memory_if.sv
// Request/response, status and commit-debug bundle for buffered_data_memory.
// master drives requests and observes responses; slave is the memory.
interface buffered_data_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        busy;
  logic        debug_enable;
  logic [31:0] debug_address;
  logic [31:0] debug_out;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_data,
    input  req_ready, resp_valid, resp_data, resp_error, busy,
    input  debug_enable, debug_address, debug_out
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_data,
    output req_ready, resp_valid, resp_data, resp_error, busy,
    output debug_enable, debug_address, debug_out
  );
endinterface

// File: rtl/buffered_data_memory.sv
// Byte memory with posted-store buffer and store-to-load forwarding; responses LATENCY cycles after accept.
// Loads never stall; valid stores stall (req_ready low) only while the store buffer is full.
module buffered_data_memory #(
  parameter int unsigned ADDRESS_WIDTH   = 12,
  parameter logic [31:0] LOW             = 32'h0,
  parameter logic [31:0] HIGH            = 32'h2fff,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned SB_DEPTH        = 4,
  parameter bit          ALLOW_UNALIGNED = 1'b0
) (
  input logic                   clk,
  input logic                   reset,
  buffered_data_memory_if.slave bus
);
  localparam int unsigned MEM_BYTES = 1 << ADDRESS_WIDTH;
  localparam int unsigned CW        = $clog2(SB_DEPTH + 1);
  localparam int unsigned AW        = ADDRESS_WIDTH;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } sb_entry_t;

  logic [7:0]         mem_q [MEM_BYTES];
  sb_entry_t          sb_q [SB_DEPTH];
  sb_entry_t          sb_d [SB_DEPTH];
  logic [CW-1:0]      sb_cnt_q, sb_cnt_d;
  logic [LATENCY-1:0] pv_q, pv_d, pe_q, pe_d;
  logic [31:0]        pd_q [LATENCY];
  logic [31:0]        pd_d [LATENCY];

  logic        size_ok, misaligned, below_low, above_high, req_err;
  logic [32:0] last_byte;
  logic        sb_full, commit, accept, push;
  sb_entry_t   head;

  always_comb begin
    size_ok   = (bus.req_size == 3'd1) || (bus.req_size == 3'd2) || (bus.req_size == 3'd4);
    last_byte = {1'b0, bus.req_address} + {30'b0, bus.req_size} - 33'd1;
    case (bus.req_size)
      3'd2:    misaligned = bus.req_address[0];
      3'd4:    misaligned = |bus.req_address[1:0];
      default: misaligned = 1'b0;
    endcase
    below_low  = $signed({2'b00, bus.req_address}) < $signed({2'b00, LOW});
    above_high = $signed({1'b0, last_byte}) > $signed({2'b00, HIGH});
    req_err    = below_low | above_high | !size_ok | (!ALLOW_UNALIGNED & misaligned);
  end

  assign sb_full       = (sb_cnt_q == CW'(SB_DEPTH));
  assign commit        = (sb_cnt_q != '0);
  assign bus.req_ready = !(bus.req_write & !req_err) | !sb_full;
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = accept & bus.req_write & !req_err;
  assign head          = sb_q[0];

  // Entry 0 is always the oldest; a commit shifts the queue down before the push lands.
  always_comb begin
    sb_d     = sb_q;
    sb_cnt_d = sb_cnt_q;
    if (commit) begin
      for (int i = 0; i < int'(SB_DEPTH) - 1; i++) sb_d[i] = sb_q[i + 1];
      sb_cnt_d = sb_cnt_q - 1'b1;
    end
    if (push) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        if (CW'(i) == sb_cnt_d) sb_d[i] = '{addr: bus.req_address, size: bus.req_size, data: bus.req_data};
      end
      sb_cnt_d = sb_cnt_d + 1'b1;
    end
  end

  logic [AW-1:0] wr_idx  [4];
  logic [7:0]    wr_byte [4];
  logic [3:0]    wr_en;
  logic [AW-1:0] word_base;
  logic [31:0]   dbg_word;
  logic [2:0]    dbg_pos;

  always_comb begin
    word_base = {head.addr[AW-1:2], 2'b00};
    dbg_word  = '0;
    dbg_pos   = '0;
    wr_en     = '0;
    for (int b = 0; b < 4; b++) begin
      wr_idx[b]  = head.addr[AW-1:0] + AW'(b);
      wr_byte[b] = head.data[8*b +: 8];
      wr_en[b]   = commit && (3'(b) < head.size);
      dbg_word[8*b +: 8] = mem_q[word_base + AW'(b)];
    end
    // Bytes that spill past the word boundary belong to the next word and are not shown.
    for (int b = 0; b < 4; b++) begin
      dbg_pos = {1'b0, head.addr[1:0]} + 3'(b);
      if ((3'(b) < head.size) && !dbg_pos[2]) dbg_word[8*dbg_pos[1:0] +: 8] = head.data[8*b +: 8];
    end
  end

  assign bus.debug_enable  = commit;
  assign bus.debug_address = commit ? {head.addr[31:2], 2'b00} : 32'h0;
  assign bus.debug_out     = commit ? dbg_word : 32'h0;

  logic [AW-1:0] ld_idx, ld_off;
  logic [7:0]    ld_byte;
  logic [31:0]   ld_raw, ld_ext;

  // Later (younger) entries overwrite earlier matches, so the last hit wins.
  always_comb begin
    ld_raw  = '0;
    ld_idx  = '0;
    ld_off  = '0;
    ld_byte = '0;
    for (int b = 0; b < 4; b++) begin
      ld_idx  = bus.req_address[AW-1:0] + AW'(b);
      ld_byte = mem_q[ld_idx];
      for (int i = 0; i < int'(SB_DEPTH); i++) begin
        ld_off = ld_idx - sb_q[i].addr[AW-1:0];
        if ((CW'(i) < sb_cnt_q) && (ld_off < AW'(sb_q[i].size))) ld_byte = sb_q[i].data[8*ld_off[1:0] +: 8];
      end
      if (3'(b) < bus.req_size) ld_raw[8*b +: 8] = ld_byte;
    end
    case (bus.req_size)
      3'd1:    ld_ext = bus.req_unsigned ? {24'h0, ld_raw[7:0]}  : {{24{ld_raw[7]}}, ld_raw[7:0]};
      3'd2:    ld_ext = bus.req_unsigned ? {16'h0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default: ld_ext = ld_raw;
    endcase
  end

  always_comb begin
    pv_d = pv_q;
    pe_d = pe_q;
    pd_d = pd_q;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    pv_d[0] = accept;
    pe_d[0] = accept & req_err;
    pd_d[0] = (accept & !bus.req_write & !req_err) ? ld_ext : 32'h0;
  end

  assign bus.resp_valid = pv_q[LATENCY-1];
  assign bus.resp_error = pe_q[LATENCY-1];
  assign bus.resp_data  = pd_q[LATENCY-1];
  assign bus.busy       = commit | (|pv_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_cnt_q <= '0;
      pv_q     <= '0;
      pe_q     <= '0;
      for (int i = 0; i < int'(SB_DEPTH); i++) sb_q[i] <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pd_q[i] <= '0;
    end else begin
      sb_cnt_q <= sb_cnt_d;
      pv_q     <= pv_d;
      pe_q     <= pe_d;
      sb_q     <= sb_d;
      pd_q     <= pd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem_q[i] <= 8'h00;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_en[b]) mem_q[wr_idx[b]] <= wr_byte[b];
      end
    end
  end
endmodule

// File: tb/tb_buffered_data_memory.sv
// Bench for buffered_data_memory: directed steps then random traffic against a program-order byte model.
module tb_buffered_data_memory;
  localparam int          LAT    = 2;
  localparam int          SBD    = 4;
  localparam int          MEMB   = 4096;
  localparam logic [31:0] LOW_A  = 32'h0;
  localparam logic [31:0] HIGH_A = 32'h2fff;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  buffered_data_memory_if bus ();

  buffered_data_memory #(
    .ADDRESS_WIDTH(12), .LOW(LOW_A), .HIGH(HIGH_A),
    .LATENCY(LAT), .SB_DEPTH(SBD), .ALLOW_UNALIGNED(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int due; logic err; logic [31:0] data; } resp_t;
  typedef struct { int rdy; logic [31:0] addr; int size; logic [31:0] data; } st_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   sb_occ = 0;
  resp_t rq[$];
  st_t   cq[$];
  logic [7:0] pmem [MEMB];   // program-order view: stores applied at acceptance
  logic [7:0] cmem [MEMB];   // committed view: stores applied as they drain

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input int sz);
    if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b1;
    if (longint'(a) < longint'(LOW_A)) return 1'b1;
    if (longint'(a) + longint'(sz) - 1 > longint'(HIGH_A)) return 1'b1;
    if ((a % 32'(sz)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int midx(input logic [31:0] a);
    return int'(a % 32'(MEMB));
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input int sz, input logic uns);
    logic [31:0] m;
    if (sz == 4) return v;
    m = 32'hffff_ffff << (8 * sz);
    if (!uns && v[8*sz-1]) return v | m;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    logic ev, de, bz;
    logic [31:0] w, base;
    if (reset) begin
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      de = (cq.size() > 0) && (cq[0].rdy <= cyc);
      sb_occ = 0;
      foreach (cq[i]) if (cq[i].rdy <= cyc) sb_occ++;
      bz = de || ((rq.size() > 0) && (rq[0].due - LAT < cyc));
      check("busy", 32'(bus.busy), 32'(bz));
      check("resp_valid", 32'(bus.resp_valid), 32'(ev));
      if (ev) begin
        check("resp_error", 32'(bus.resp_error), 32'(rq[0].err));
        check("resp_data", bus.resp_data, rq[0].data);
        void'(rq.pop_front());
      end
      check("debug_enable", 32'(bus.debug_enable), 32'(de));
      if (de) begin
        for (int b = 0; b < cq[0].size; b++) cmem[midx(cq[0].addr + 32'(b))] = cq[0].data[8*b +: 8];
        base = {cq[0].addr[31:2], 2'b00};
        for (int k = 0; k < 4; k++) w[8*k +: 8] = cmem[midx(base + 32'(k))];
        check("debug_address", bus.debug_address, base);
        check("debug_out", bus.debug_out, w);
        void'(cq.pop_front());
      end
    end
  end

  task automatic req(input logic wr, input int sz, input logic uns, input logic [31:0] a, input logic [31:0] d);
    logic e, rdy_exp;
    logic [31:0] v;
    int g;
    e = exp_err(a, sz);
    g = 0;
    @(negedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = 3'(sz);
    bus.req_unsigned = uns;
    bus.req_address  = a;
    bus.req_data     = d;
    #1;
    forever begin
      rdy_exp = !(wr && !e) || (sb_occ < SBD);
      check("req_ready", 32'(bus.req_ready), 32'(rdy_exp));
      if (bus.req_ready) break;
      g++;
      if (g > 20) begin
        tests++;
        fails++;
        $error("FAIL stall_bound observed=stalled>20 expected=accept addr=0x%08h", a);
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk); #2;
    end
    if (e) begin
      rq.push_back('{due: cyc + LAT, err: 1'b1, data: 32'h0});
    end else if (wr) begin
      for (int b = 0; b < sz; b++) pmem[midx(a + 32'(b))] = d[8*b +: 8];
      cq.push_back('{rdy: cyc + 1, addr: a, size: sz, data: d});
      rq.push_back('{due: cyc + LAT, err: 1'b0, data: 32'h0});
    end else begin
      v = 32'h0;
      for (int b = 0; b < sz; b++) v[8*b +: 8] = pmem[midx(a + 32'(b))];
      rq.push_back('{due: cyc + LAT, err: 1'b0, data: extend(v, sz, uns)});
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rq.delete();
    cq.delete();
    for (int i = 0; i < MEMB; i++) begin
      pmem[i] = 8'h00;
      cmem[i] = 8'h00;
    end
    sb_occ = 0;
    reset = 1'b1;
    @(negedge clk); #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_error", 32'(bus.resp_error), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_debug_enable", 32'(bus.debug_enable), 32'd0);
  endtask

  task automatic drain();
    int g;
    idle(1);
    g = 0;
    while ((rq.size() > 0 || cq.size() > 0) && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (rq.size() > 0 || cq.size() > 0) begin
      tests++;
      fails++;
      $error("FAIL drain observed=%0d/%0d pending expected=0/0", rq.size(), cq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=no finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    int sz, r;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 3'd0;
    bus.req_unsigned = 1'b0;
    bus.req_address  = 32'h0;
    bus.req_data     = 32'h0;
    do_reset();

    // reset contents read as zero
    req(1'b0, 4, 1'b0, 32'h100, 32'h0);
    idle(LAT + 2);

    // forwarding from a store still in the buffer
    req(1'b1, 4, 1'b0, 32'h10, 32'h8899AABB);
    req(1'b0, 1, 1'b0, 32'h11, 32'h0);
    idle(4);

    // five back-to-back stores, then read each back
    for (int i = 0; i < 5; i++) req(1'b1, 4, 1'b0, 32'h200 + 32'(4 * i), $urandom);
    for (int i = 0; i < 5; i++) req(1'b0, 4, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
    idle(4);

    // error cases and range edges
    req(1'b0, 4, 1'b0, 32'h2, 32'h0);
    req(1'b1, 4, 1'b0, 32'h3000, 32'hDEADBEEF);
    req(1'b1, 4, 1'b0, 32'h2ffe, 32'h11111111);
    req(1'b1, 4, 1'b0, 32'h2ffc, 32'hCAFEF00D);
    req(1'b1, 2, 1'b0, 32'h2fff, 32'h2222);
    req(1'b1, 1, 1'b0, 32'h2fff, 32'h000000E7);
    req(1'b0, 3, 1'b0, 32'h20, 32'h0);
    req(1'b0, 1, 1'b0, 32'h2fff, 32'h0);
    req(1'b0, 4, 1'b1, 32'h0ffc, 32'h0);
    req(1'b0, 2, 1'b0, 32'h2ffe, 32'h0);
    idle(4);

    // youngest byte wins
    req(1'b1, 2, 1'b0, 32'h6, 32'h1234);
    req(1'b1, 1, 1'b0, 32'h7, 32'h56);
    req(1'b0, 2, 1'b1, 32'h6, 32'h0);
    idle(4);

    // reset with stores and loads in flight
    req(1'b1, 4, 1'b0, 32'h40, 32'h01020304);
    req(1'b1, 4, 1'b0, 32'h44, 32'hF0E0D0C0);
    req(1'b0, 4, 1'b0, 32'h40, 32'h0);
    req(1'b0, 4, 1'b0, 32'h44, 32'h0);
    req(1'b0, 4, 1'b0, 32'h10, 32'h0);
    do_reset();
    req(1'b0, 4, 1'b0, 32'h40, 32'h0);
    req(1'b0, 4, 1'b0, 32'h10, 32'h0);
    req(1'b0, 2, 1'b1, 32'h6, 32'h0);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 9));
      sz = (r < 4) ? 4 : (r < 7) ? 2 : (r < 9) ? 1 : int'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 * $urandom_range(1, 2) + $urandom_range(0, 63);
        1:       a = 32'h2ff8 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 63);
      endcase
      if ($urandom_range(0, 7) != 0 && (sz == 2 || sz == 4)) a = a & ~(32'(sz) - 32'd1);
      d = $urandom;
      req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    drain();
    @(negedge clk); #2;
    check("final_busy", 32'(bus.busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
